// File: rtl/fmap_input_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fmap_buf_pkg                                                        |
// | Derived sizes and element-to-lane/address mapping for the buffer.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package fmap_buf_pkg;

  typedef struct packed {
    logic [31:0] lane;
    logic [31:0] addr;
  } lane_addr_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int groups_of(input int in_ch, input int par_ch);
    return in_ch / par_ch;
  endfunction

  function automatic int pixels_of(input int width, input int height);
    return width * height;
  endfunction

  // Two extra bits: one for sign, one so that width/height itself is representable.
  function automatic int cw_of(input int width, input int height);
    return clog2(max2(width, height)) + 2;
  endfunction

  function automatic int gw_of(input int groups);
    return max2(1, clog2(groups));
  endfunction

  function automatic lane_addr_t map_elem(input int bank, input int pixel, input int ch,
                                          input int in_ch, input int par_ch, input int pixels);
    lane_addr_t m;
    int groups;
    groups = in_ch / par_ch;
    m.lane = ch % par_ch;
    m.addr = bank * pixels * groups + pixel * groups + ch / par_ch;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_input_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fmap_input_buffer_if                                                |
// | Stream-load and coordinate-read bus of the feature-map buffer.      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface fmap_input_buffer_if
  import fmap_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_CH     = 3,
  parameter int CW         = cw_of(5, 5),
  parameter int GW         = 1
);
  logic [DATA_WIDTH-1:0]        wr_data;
  logic                         wr_valid;
  logic                         wr_ready;
  logic                         rd_bank_ready;
  logic                         rd_en;
  logic [CW-1:0]                rd_x;
  logic [CW-1:0]                rd_y;
  logic [GW-1:0]                rd_grp;
  logic [DATA_WIDTH*PAR_CH-1:0] rd_data;
  logic                         rd_valid;
  logic                         rd_release;

  modport master (
    output wr_data, wr_valid, rd_en, rd_x, rd_y, rd_grp, rd_release,
    input  wr_ready, rd_bank_ready, rd_data, rd_valid
  );

  modport slave (
    input  wr_data, wr_valid, rd_en, rd_x, rd_y, rd_grp, rd_release,
    output wr_ready, rd_bank_ready, rd_data, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/fmap_input_buffer_bram_sdp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bram_sdp                                                            |
// | Simple dual-port RAM: one write port, one registered read port.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module bram_sdp #(
  parameter int    WIDTH     = 8,
  parameter int    DEPTH     = 16,
  parameter int    AW        = 4,
  parameter string RAM_STYLE = "auto"
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic             re,
  input  wire logic [AW-1:0]    raddr,
  output logic      [WIDTH-1:0] rdata
);
  (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/fmap_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fmap_input_buffer                                                   |
// | Ping-pong input feature-map buffer with zero-padded PAR_CH reads.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module fmap_input_buffer
  import fmap_buf_pkg::*;
#(
  parameter int    DATA_WIDTH  = 8,
  parameter int    IN_CHANNELS = 3,
  parameter int    IN_WIDTH    = 5,
  parameter int    IN_HEIGHT   = 5,
  parameter int    PAR_CH      = 3,
  parameter int    PAD_VALUE   = 0,
  parameter string RAM_STYLE   = "auto"
) (
  input wire logic           clk,
  input wire logic           rst,
  fmap_input_buffer_if.slave bus
);
  localparam int GROUPS  = groups_of(IN_CHANNELS, PAR_CH);
  localparam int PIXELS  = pixels_of(IN_WIDTH, IN_HEIGHT);
  localparam int CW      = cw_of(IN_WIDTH, IN_HEIGHT);
  localparam int GW      = gw_of(GROUPS);
  localparam int BANK_SZ = PIXELS * GROUPS;
  localparam int DEPTH   = 2 * BANK_SZ;
  localparam int AW      = max2(1, clog2(DEPTH));
  localparam int PW      = max2(1, clog2(PIXELS));
  localparam int CHW     = max2(1, clog2(IN_CHANNELS));

  localparam logic [PW-1:0]         c_pix_last = PW'(PIXELS - 1);
  localparam logic [CHW-1:0]        c_ch_last  = CHW'(IN_CHANNELS - 1);
  localparam logic [DATA_WIDTH-1:0] c_pad      = DATA_WIDTH'(PAD_VALUE);

  logic [1:0]     r_full;
  logic           r_wb;
  logic           r_rb;
  logic [PW-1:0]  r_pix_cnt;
  logic [CHW-1:0] r_ch_cnt;
  logic           r_rd_valid;
  logic           r_pad;
  logic           r_has_data;

  logic w_wr_fire, w_last, w_rel, w_rd_fire, w_in_frame, w_ram_re;
  logic signed [CW-1:0] w_sx, w_sy;
  logic [GW-1:0]        w_grp;
  int                   w_x, w_y, w_rd_addr;
  lane_addr_t           w_map;
  logic [DATA_WIDTH*PAR_CH-1:0] w_rd_data;
  logic                 w_unused;

  assign w_wr_fire = bus.wr_valid && !r_full[r_wb];
  assign w_last    = w_wr_fire && (r_pix_cnt == c_pix_last) && (r_ch_cnt == c_ch_last);
  assign w_rel     = bus.rd_release && r_full[r_rb];
  assign w_rd_fire = bus.rd_en && r_full[r_rb];
  assign w_sx      = bus.rd_x;
  assign w_sy      = bus.rd_y;
  assign w_grp     = bus.rd_grp;

  always_comb begin
    w_map      = map_elem(int'(r_wb), int'(r_pix_cnt), int'(r_ch_cnt),
                          IN_CHANNELS, PAR_CH, PIXELS);
    w_x        = int'(w_sx);
    w_y        = int'(w_sy);
    w_in_frame = (w_x >= 0) && (w_x < IN_WIDTH) && (w_y >= 0) && (w_y < IN_HEIGHT);
    w_rd_addr  = int'(r_rb) * BANK_SZ + (w_y * IN_WIDTH + w_x) * GROUPS + int'(w_grp);
    w_ram_re   = w_rd_fire && w_in_frame;
    w_unused   = ^{w_map.addr[31:AW], w_rd_addr[31:AW]};
  end

  // Completion and release always target different banks, so both may land together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
      r_pix_cnt <= '0;
      r_ch_cnt  <= '0;
    end else begin
      if (w_wr_fire) begin
        if (r_ch_cnt == c_ch_last) begin
          r_ch_cnt  <= '0;
          r_pix_cnt <= (r_pix_cnt == c_pix_last) ? '0 : r_pix_cnt + 1'b1;
        end else begin
          r_ch_cnt <= r_ch_cnt + 1'b1;
        end
      end
      if (w_last) begin
        r_full[r_wb] <= 1'b1;
        r_wb         <= ~r_wb;
      end
      if (w_rel) begin
        r_full[r_rb] <= 1'b0;
        r_rb         <= ~r_rb;
      end
    end
  end

  // Pad flag is registered alongside the RAM read so the mux lines up with its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_pad      <= 1'b0;
      r_has_data <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_pad      <= !w_in_frame;
        r_has_data <= 1'b1;
      end
    end
  end

  for (genvar j = 0; j < PAR_CH; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_q;

    bram_sdp #(
      .WIDTH     (DATA_WIDTH),
      .DEPTH     (DEPTH),
      .AW        (AW),
      .RAM_STYLE (RAM_STYLE)
    ) u_ram (
      .clk   (clk),
      .we    (w_wr_fire && (w_map.lane == j)),
      .waddr (w_map.addr[AW-1:0]),
      .wdata (bus.wr_data),
      .re    (w_ram_re),
      .raddr (w_rd_addr[AW-1:0]),
      .rdata (w_q)
    );

    assign w_rd_data[(j+1)*DATA_WIDTH-1 -: DATA_WIDTH] =
      !r_has_data ? '0 : (r_pad ? c_pad : w_q);
  end

  assign bus.wr_ready      = !r_full[r_wb];
  assign bus.rd_bank_ready = r_full[r_rb];
  assign bus.rd_valid      = r_rd_valid;
  assign bus.rd_data       = w_rd_data;
endmodule
`default_nettype wire

// File: tb/tb_fmap_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fmap_input_buffer                                                |
// | Directed self-checking bench: 4 channels, 2 lanes, 3x3 frame.       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_fmap_input_buffer;
  localparam int DW = 8;
  localparam int IC = 4;
  localparam int PC = 2;
  localparam int W  = 3;
  localparam int H  = 3;
  localparam int CW = 4;
  localparam int GW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   acc, fb;

  fmap_input_buffer_if #(.DATA_WIDTH(DW), .PAR_CH(PC), .CW(CW), .GW(GW)) bus ();

  fmap_input_buffer #(
    .DATA_WIDTH (DW),
    .IN_CHANNELS(IC),
    .IN_WIDTH   (W),
    .IN_HEIGHT  (H),
    .PAR_CH     (PC),
    .PAD_VALUE  (0),
    .RAM_STYLE  ("auto")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Two-lane word for pixel (x,y), group g of a frame whose element e holds base+e.
  function automatic logic [15:0] pair(input int base, input int x, input int y, input int g);
    int e;
    e = (y * W + x) * IC + g * PC;
    return {8'(base + e + 1), 8'(base + e)};
  endfunction

  task automatic stream(input int n, input int base, output int accepted, output int first_block);
    accepted    = 0;
    first_block = -1;
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(base + accepted);
      if (bus.wr_ready) accepted++;
      else if (first_block < 0) first_block = i;
      tick;
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd(input int x, input int y, input int g, input logic [15:0] exp, input string tag);
    bus.rd_en  = 1'b1;
    bus.rd_x   = 4'(x);
    bus.rd_y   = 4'(y);
    bus.rd_grp = 1'(g);
    tick;
    bus.rd_en = 1'b0;
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic release_pulse;
    bus.rd_release = 1'b1;
    tick;
    bus.rd_release = 1'b0;
  endtask

  initial begin
    bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_en = 1'b0;
    bus.rd_x = '0; bus.rd_y = '0; bus.rd_grp = '0; bus.rd_release = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    check("reset_wr_ready",   32'(bus.wr_ready),      32'd1);
    check("reset_bank_ready", 32'(bus.rd_bank_ready), 32'd0);
    check("reset_rd_valid",   32'(bus.rd_valid),      32'd0);
    check("reset_rd_data",    32'(bus.rd_data),       32'd0);

    // Operations that must be ignored while nothing is full
    bus.rd_en = 1'b1;
    tick;
    bus.rd_en = 1'b0;
    check("ign_rd_valid", 32'(bus.rd_valid), 32'd0);
    release_pulse;
    check("ign_rel_wr_ready",   32'(bus.wr_ready),      32'd1);
    check("ign_rel_bank_ready", 32'(bus.rd_bank_ready), 32'd0);

    // Frame 1 into bank 0 (values 0..35)
    stream(36, 0, acc, fb);
    check("f1_accepted",   32'(acc),               32'd36);
    check("f1_bank_ready", 32'(bus.rd_bank_ready), 32'd1);
    check("f1_wr_ready",   32'(bus.wr_ready),      32'd1);

    rd(1, 1, 1, 16'h1312, "f1_center");
    rd(-1, 0, 0, 16'h0000, "pad_left");
    rd(3, 2, 0, 16'h0000, "pad_right");
    rd(0, -1, 0, 16'h0000, "pad_top");
    rd(2, 2, 1, pair(0, 2, 2, 1), "f1_corner");
    tick;
    check("hold_valid", 32'(bus.rd_valid), 32'd0);
    check("hold_data",  32'(bus.rd_data),  32'h2322);

    // Frame 2 into bank 1; its last beat coincides with a release and a read of bank 0
    stream(35, 36, acc, fb);
    check("f2_accepted", 32'(acc), 32'd35);
    bus.wr_valid = 1'b1; bus.wr_data = 8'(36 + 35);
    bus.rd_release = 1'b1;
    bus.rd_en = 1'b1; bus.rd_x = 4'd0; bus.rd_y = 4'd0; bus.rd_grp = 1'b0;
    tick;
    bus.wr_valid = 1'b0; bus.rd_release = 1'b0; bus.rd_en = 1'b0;
    check("sim_rd_valid",   32'(bus.rd_valid),      32'd1);
    check("sim_rd_data",    32'(bus.rd_data),       32'h0100);
    check("sim_wr_ready",   32'(bus.wr_ready),      32'd1);
    check("sim_bank_ready", 32'(bus.rd_bank_ready), 32'd1);
    rd(1, 1, 1, pair(36, 1, 1, 1), "f2_center");

    // Frame 3 fills bank 0, then writes stall until bank 1 is released
    stream(80, 100, acc, fb);
    check("bp1_accepted",    32'(acc),          32'd36);
    check("bp1_first_block", 32'(fb),           32'd36);
    check("bp1_wr_ready",    32'(bus.wr_ready), 32'd0);
    release_pulse;
    check("rel_wr_ready",   32'(bus.wr_ready),      32'd1);
    check("rel_bank_ready", 32'(bus.rd_bank_ready), 32'd1);
    rd(1, 1, 1, pair(100, 1, 1, 1), "f3_center");

    // Asynchronous reset in the middle of a partial frame
    stream(10, 7, acc, fb);
    rst = 1'b1;
    #1;
    check("rst_wr_ready",   32'(bus.wr_ready),      32'd1);
    check("rst_bank_ready", 32'(bus.rd_bank_ready), 32'd0);
    check("rst_rd_valid",   32'(bus.rd_valid),      32'd0);
    check("rst_rd_data",    32'(bus.rd_data),       32'd0);
    tick;
    rst = 1'b0;
    tick;

    // Both banks from empty: 72 beats accepted, stall from beat 73
    stream(80, 150, acc, fb);
    check("bp2_accepted",    32'(acc),               32'd72);
    check("bp2_first_block", 32'(fb),                32'd72);
    check("bp2_bank_ready",  32'(bus.rd_bank_ready), 32'd1);
    check("bp2_wr_ready",    32'(bus.wr_ready),      32'd0);
    rd(1, 1, 1, pair(150, 1, 1, 1), "f4_center");
    rd(2, 2, 1, pair(150, 2, 2, 1), "f4_corner");
    release_pulse;
    check("rel2_wr_ready", 32'(bus.wr_ready), 32'd1);
    rd(1, 1, 1, pair(186, 1, 1, 1), "f5_center");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fmap_input_buffer.md
# fmap_input_buffer

Double-buffered (ping-pong) input feature-map buffer for the convolution datapath. It accepts a streamed frame of activations, one element per beat, stored pixel-major and channel-minor. It serves reads of PAR_CH channels at a time for a signed (x, y) pixel coordinate. Coordinates outside the frame return PAD_VALUE, which gives zero-padding for k×k convolutions. While the compute engine reads one bank, the loader fills the other.

## Interface
- DATA_WIDTH, 8, element width
- IN_CHANNELS, 3, channels per pixel
- IN_WIDTH, 5, frame width in pixels
- IN_HEIGHT, 5, frame height in pixels
- PAR_CH, 3, channels returned per read; must divide IN_CHANNELS
- PAD_VALUE, 0, element value returned for out-of-frame coordinates
- RAM_STYLE, "auto", ram_style attribute for the lane RAMs
- Derived values:
  - GROUPS = IN_CHANNELS/PAR_CH
  - PIXELS = IN_WIDTH*IN_HEIGHT
  - CW = $clog2(max(IN_WIDTH, IN_HEIGHT)) + 2
  - GW = max(1, $clog2(GROUPS))

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_data  in  DATA_WIDTH  streamed element
- wr_valid  in  1  wr_data is valid
- wr_ready  out  1  write bank can accept an element
- rd_bank_ready  out  1  a complete frame is available for reading
- rd_en  in  1  read request
- rd_x  in  CW  signed pixel column (two's complement)
- rd_y  in  CW  signed pixel row (two's complement)
- rd_grp  in  GW  channel group; selects channels rd_grp*PAR_CH .. +PAR_CH-1
- rd_data  out  DATA_WIDTH*PAR_CH  lane j at bits [(j+1)*DATA_WIDTH-1 -: DATA_WIDTH] holds channel rd_grp*PAR_CH+j
- rd_valid  out  1  rd_data is valid (1-cycle pulse per accepted read)
- rd_release  in  1  pulse: consumer has finished with the current read bank

## Operation
- Storage is split into PAR_CH lane RAMs, each 2*PIXELS*GROUPS deep.
  - Element e = pixel*IN_CHANNELS + c goes to lane c%PAR_CH.
  - Address within the lane RAM is bank*PIXELS*GROUPS + pixel*GROUPS + c/PAR_CH.
- State held by the block:
  - full[1:0]: per-bank full flags
  - wb: write-bank pointer
  - rb: read-bank pointer
  - write counters: ch_cnt (0..IN_CHANNELS-1) and pix_cnt (0..PIXELS-1)
- Write path:
  - wr_ready = !full[wb].
  - A beat is accepted when wr_valid && wr_ready; ch_cnt increments and wraps into pix_cnt.
  - Accepting the final beat (pix_cnt=PIXELS-1, ch_cnt=IN_CHANNELS-1) sets full[wb], toggles wb and clears both counters.
- Read path:
  - rd_bank_ready = full[rb].
  - A read is accepted when rd_en && rd_bank_ready; reads while not ready are ignored (rd_valid stays 0).
  - In-frame means 0 ≤ rd_x < IN_WIDTH and 0 ≤ rd_y < IN_HEIGHT.
  - In-frame read: address = rb*PIXELS*GROUPS + (rd_y*IN_WIDTH + rd_x)*GROUPS + rd_grp, issued to all lanes.
  - Out-of-frame read: every lane returns PAD_VALUE; no RAM address matters.
- Release:
  - rd_release with full[rb] clears full[rb] and toggles rb.
  - rd_release with !full[rb] is ignored.
- Simultaneous events:
  - Frame completion and release in the same cycle on different banks: both take effect.
  - A read and a release in the same cycle: the read completes from the old bank.
- Reset:
  - full=0, wb=rb=0, counters=0, rd_data=0, rd_valid=0; wr_ready=1 and rd_bank_ready=0 after reset.
  - RAM contents are not cleared.
  - A partially written frame is discarded on reset.

## Timing
- Read latency is 1 cycle: rd_data and rd_valid are registered and appear on the edge after acceptance.
- rd_data holds its last value when no read is accepted.
- Back-to-back reads sustain 1 result per cycle.
- rd_bank_ready rises in the cycle after the final write beat is accepted.
- wr_ready rises in the cycle after the rd_release that frees the blocked bank.
- Write throughput is 1 element/cycle; a full frame takes PIXELS*IN_CHANNELS accepted beats.
- Both banks full: wr_ready=0 until a release.

## Structure
- Shared package/header fmap_buf_pkg holds:
  - clog2/max helper functions
  - the GROUPS, PIXELS, CW and GW derivations
  - the element-to-lane/address mapping function, so the loader and the testbench compute the same mapping
- Sub-module bram_sdp: simple dual-port RAM (1 write port, 1 registered read port) with RAM_STYLE; instantiated PAR_CH times.
- Top level holds:
  - the write counters and bank/flag control
  - the coordinate bounds check
  - the pad mux, which must be aligned to the RAM read latency (registered out-of-frame flag)

## Test plan
- Configuration: IN_CHANNELS=4, PAR_CH=2, 3×3 frame. Write elements 0..35 as values 0..35; read (x=1, y=1, grp=1) -> one cycle later rd_valid=1, rd_data={8'd19, 8'd18}.
- Padding: reads at (-1,0), (3,2) and (0,-1), each with grp=0 -> rd_valid=1, rd_data=0 each cycle. A read at (2,2) grp=1 -> {35, 34}.
- Back-pressure: stream 80 beats without release -> first 72 accepted; wr_ready=0 from beat 73. Pulse rd_release -> wr_ready=1 next cycle; frame 2 is now read from bank 1.
- Ignored operations: rd_en with rd_bank_ready=0 -> rd_valid stays 0. rd_release with no full bank -> wb, rb and flags unchanged.
- Simultaneous events: final beat of frame 2 and release of frame 1 in the same cycle -> full={1,0} afterward; wr_ready=1; rb=1.
- Reset mid-frame: assert rst after 10 beats -> all outputs at reset values. A fresh 36-beat frame is then read back correctly from bank 0.
